// File: rtl/ttm4_register_bank.sv
// Eight loadable registers (one doubling as an auto-incrementing PC), carry flag and readback port.
// Loads/increment visible 1 cycle after the edge; RDATA 1 cycle after RSEL; CE=0 freezes state, RDATA keeps tracking.
module ttm4_register_bank #(
  parameter int               WIDTH    = 4,
  parameter int               PC_INDEX = 7,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic [7:0]         nLD,
  input  logic [WIDTH-1:0]   D,
  input  logic               CI,
  input  logic [2:0]         RSEL,
  output logic [8*WIDTH-1:0] Q,
  output logic [WIDTH-1:0]   PC,
  output logic               CF,
  output logic [WIDTH-1:0]   RDATA,
  output logic               PC_WRAP
);

  logic [WIDTH-1:0] r_regs [8];
  logic             r_cf;
  logic             r_pc_wrap;
  logic [WIDTH-1:0] r_rdata;

  logic             w_pc_inc;
  logic             w_pc_ones;

  assign w_pc_inc  = nLD[PC_INDEX];
  assign w_pc_ones = &r_regs[PC_INDEX];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= (i == PC_INDEX) ? RESET_PC : '0;
      end
      r_cf      <= 1'b0;
      r_pc_wrap <= 1'b0;
      r_rdata   <= '0;
    end else begin
      // Readback samples the pre-edge contents and runs even while halted.
      r_rdata <= r_regs[RSEL];
      if (CE) begin
        for (int i = 0; i < 8; i++) begin
          if (!nLD[i]) begin
            r_regs[i] <= D;
          end else if (i == PC_INDEX) begin
            r_regs[i] <= r_regs[i] + WIDTH'(1);
          end
        end
        r_cf      <= CI;
        r_pc_wrap <= w_pc_inc & w_pc_ones;
      end else begin
        r_pc_wrap <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign Q[g*WIDTH +: WIDTH] = r_regs[g];
  end

  assign PC      = r_regs[PC_INDEX];
  assign CF      = r_cf;
  assign RDATA   = r_rdata;
  assign PC_WRAP = r_pc_wrap;

endmodule

// File: tb/tb_ttm4_register_bank.sv
// Directed bench for ttm4_register_bank: stimulus queues expected values, a monitor drains and compares them.
module tb_ttm4_register_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [7:0]  nLD;
  logic [3:0]  D;
  logic        CI;
  logic [2:0]  RSEL;
  logic [31:0] Q;
  logic [3:0]  PC;
  logic        CF;
  logic [3:0]  RDATA;
  logic        PC_WRAP;

  ttm4_register_bank #(.WIDTH(4), .PC_INDEX(7), .RESET_PC(4'h0)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .nLD(nLD), .D(D), .CI(CI), .RSEL(RSEL),
    .Q(Q), .PC(PC), .CF(CF), .RDATA(RDATA), .PC_WRAP(PC_WRAP)
  );

  always #5 CLK = ~CLK;

  localparam int S_Q = 0, S_PC = 1, S_CF = 2, S_RD = 3, S_WR = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event chk_ev;

  task automatic exp_push(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: outputs are sampled on the falling edge, or on demand between edges.
  initial begin
    forever begin
      @(negedge CLK or chk_ev);
      while (sb.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sel)
          S_Q:     act = Q;
          S_PC:    act = {28'h0, PC};
          S_CF:    act = {31'h0, CF};
          S_RD:    act = {28'h0, RDATA};
          default: act = {31'h0, PC_WRAP};
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; CE = 1'b0; nLD = 8'hFF; D = 4'h0; CI = 1'b0; RSEL = 3'd0;

    step();
    exp_push("rst_q", S_Q, 32'h0);
    exp_push("rst_pc", S_PC, 32'h0);
    exp_push("rst_cf", S_CF, 32'h0);
    exp_push("rst_rdata", S_RD, 32'h0);
    exp_push("rst_wrap", S_WR, 32'h0);
    RST = 1'b0;

    // Load reg0 = 5; PC increments alongside.
    CE = 1'b1; nLD = 8'hFE; D = 4'h5;
    step();
    exp_push("load_q", S_Q, 32'h1000_0005);
    exp_push("load_pc", S_PC, 32'h1);
    nLD = 8'hFF; RSEL = 3'd0;
    step();
    exp_push("readback_r0", S_RD, 32'h5);
    exp_push("inc_pc", S_PC, 32'h2);

    // Build PC=9, reg0=3, CF=1 for the mid-run reset.
    nLD = 8'h7F; D = 4'h8;
    step();
    nLD = 8'hFE; D = 4'h3; CI = 1'b1;
    step();
    exp_push("pre_rst_q", S_Q, 32'h9000_0003);
    exp_push("pre_rst_cf", S_CF, 32'h1);

    // Reset between edges, with a load pending, must act with no clock edge.
    @(negedge CLK);
    #2;
    RST = 1'b1; nLD = 8'h00; D = 4'hF;
    #1;
    exp_push("async_rst_q", S_Q, 32'h0);
    exp_push("async_rst_pc", S_PC, 32'h0);
    exp_push("async_rst_cf", S_CF, 32'h0);
    exp_push("async_rst_rdata", S_RD, 32'h0);
    exp_push("async_rst_wrap", S_WR, 32'h0);
    -> chk_ev;
    step();
    exp_push("rst_over_load_q", S_Q, 32'h0);
    RST = 1'b0; nLD = 8'hFF; CI = 1'b0;

    // Wrap by increment.
    nLD = 8'h7F; D = 4'hF;
    step();
    exp_push("pc_to_f", S_PC, 32'hF);
    exp_push("no_wrap_on_load", S_WR, 32'h0);
    nLD = 8'hFF;
    step();
    exp_push("wrap_pc", S_PC, 32'h0);
    exp_push("wrap_pulse", S_WR, 32'h1);
    step();
    exp_push("after_wrap_pc", S_PC, 32'h1);
    exp_push("wrap_one_cycle", S_WR, 32'h0);

    // Load has priority over increment at PC=F.
    nLD = 8'h7F; D = 4'hF;
    step();
    D = 4'hA;
    step();
    exp_push("pc_load_prio", S_PC, 32'hA);
    exp_push("pc_load_no_wrap", S_WR, 32'h0);

    // reg3 and PC loaded together with F.
    nLD = 8'h77; D = 4'hF;
    step();
    exp_push("multi_load_q", S_Q, 32'hF000_F000);

    // Halted: nothing changes, readback keeps tracking RSEL.
    CE = 1'b0; nLD = 8'h00; D = 4'hC; CI = 1'b1;
    begin
      logic [2:0] rs [5];
      logic [3:0] rd [5];
      rs = '{3'd3, 3'd0, 3'd7, 3'd1, 3'd3};
      rd = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
      for (int k = 0; k < 5; k++) begin
        RSEL = rs[k];
        step();
        exp_push($sformatf("hold_q_%0d", k), S_Q, 32'hF000_F000);
        exp_push($sformatf("hold_cf_%0d", k), S_CF, 32'h0);
        exp_push($sformatf("hold_wrap_%0d", k), S_WR, 32'h0);
        exp_push($sformatf("hold_rdata_%0d", k), S_RD, {28'h0, rd[k]});
      end
    end

    // Single step loads every register; PC at F is loaded, so no wrap.
    CE = 1'b1;
    step();
    exp_push("step_q", S_Q, 32'hCCCC_CCCC);
    exp_push("step_pc", S_PC, 32'hC);
    exp_push("step_cf", S_CF, 32'h1);
    exp_push("step_wrap", S_WR, 32'h0);

    // Same-edge write is not forwarded to readback.
    RSEL = 3'd2; nLD = 8'hFB; D = 4'h7; CI = 1'b0;
    step();
    exp_push("hazard_old", S_RD, 32'hC);
    exp_push("hazard_cf", S_CF, 32'h0);
    nLD = 8'hFF;
    step();
    exp_push("hazard_new", S_RD, 32'h7);
    exp_push("hazard_pc", S_PC, 32'hE);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
